four_bit_adder: RTL and testbench
=================================

Name: four_bit_adder

Overview:
- 4-bit ripple-carry binary adder with carry-in and carry-out.
- The primary sum and carry outputs are purely combinational, for direct use by arithmetic datapaths.
- A registered result copy with a valid flag is provided for clocked consumers.
- Leaf arithmetic block inside the team's arithmetic-operations circuit library.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  Single clock; rising-edge. Used only by the registered result path.
- rst_n  input  1  Asynchronous, active-low reset.
- x  input  4 ([0:3], index 0 = MSB)  Addend A, unsigned.
- y  input  4 ([0:3], index 0 = MSB)  Addend B, unsigned.
- carry_in  input  1  Carry into the LSB (index 3).
- in_valid  input  1  Qualifies x/y/carry_in for capture into the registered path.
- sum  output  4 ([0:3], index 0 = MSB)  Combinational sum bits.
- carry_out  output  1  Combinational carry out of the MSB.
- overflow  output  1  Combinational two's-complement overflow flag.
- sum_q  output  4 ([0:3])  Registered sum.
- carry_out_q  output  1  Registered carry_out.
- overflow_q  output  1  Registered overflow.
- valid_q  output  1  Registered result valid.

Behaviour:
- Bit ordering: all 4-bit buses are declared [0:3], with index 0 as MSB and index 3 as LSB. Numeric value is identical to a conventional [3:0] vector. The carry chain runs from index 3 toward index 0.

Combinational path:
- {carry_out, sum} = x + y + carry_in, as a 5-bit unsigned result in 0..31.
- Structure: four full-adder slices in ripple order.
  - Slice i: s_i = x_i ^ y_i ^ c_i.
  - Carry: c_next = (x_i & y_i) | (c_i & (x_i ^ y_i)).
  - LSB slice carry-in is carry_in.
  - carry_out is the carry out of the index-0 slice.
- overflow = carry into the MSB slice XOR carry_out. This equals 1 when x[0]==y[0] and sum[0]!=x[0].
- Outputs are independent of clk and rst_n. They must settle within one simulation time unit of an input change, with no added delays.
- No latches; no state in this path.

Registered path:
- Reset: while rst_n is low, sum_q=0000, carry_out_q=0, overflow_q=0, valid_q=0. Takes effect asynchronously on the falling edge of rst_n and holds until rst_n rises.
- Rising clk edge with in_valid=1: capture sum, carry_out and overflow into sum_q, carry_out_q and overflow_q; set valid_q=1.
- Rising clk edge with in_valid=0: hold sum_q, carry_out_q and overflow_q unchanged; set valid_q=0.
- Latency: exactly one clock from in_valid sampled high to the matching valid_q=1. Back-to-back valids give one result per cycle. There is no backpressure.
- Reset asserted mid-stream: pending results are discarded and valid_q drops immediately. The first capture after reset release occurs on the first rising edge with rst_n=1 and in_valid=1.
- X/Z on inputs is not required to be handled; X propagates.

Boundary conditions:
- Max: 1111+1111+1 = 1_1111 (carry_out=1, sum=1111).
- Wrap: 1111+0001+0 = 1_0000.
- Zero: 0000+0000+0 = 0_0000.
- carry_in=1 with x=y=0000 gives sum 0001.

Test Plan:
- Directed: x=0101, y=0011, carry_in=0 -> after #1: sum=1000, carry_out=0, overflow=1.
- Wrap: x=1111, y=0001, carry_in=0 -> sum=0000, carry_out=1, overflow=0. Then x=1111, y=1111, carry_in=1 -> sum=1111, carry_out=1, overflow=0.
- Exhaustive: all 512 combinations of x, y, carry_in -> {carry_out,sum} == x+y+carry_in, and overflow matches the sign rule, each checked #1 after applying inputs with clk idle.
- Registered path: rst_n=0 -> sum_q=0000, valid_q=0. Release rst_n, drive x=0010, y=0111, carry_in=1, in_valid=1 for one edge -> next cycle sum_q=1010, carry_out_q=0, overflow_q=1, valid_q=1. Following cycle with in_valid=0 -> valid_q=0, sum_q still 1010.
- Async reset mid-stream: with valid_q=1, drop rst_n between clock edges -> sum_q, carry_out_q, overflow_q and valid_q clear immediately without waiting for clk. The combinational sum keeps tracking the inputs during reset.

Source files
------------

// File: rtl/four_bit_adder.sv
// Purpose: 4-bit ripple-carry adder with combinational sum/carry/overflow and a registered result copy.
// Latency: combinational outputs 0 cycles; registered copy 1 cycle after in_valid is sampled high.
// Backpressure: none; one result accepted per clock whenever in_valid is high.
//
// Ports:
//   clk, rst_n       clock for the registered path; asynchronous active-low reset
//   x, y, carry_in   unsigned addends ([0:3], index 0 = MSB) and carry into the LSB
//   in_valid         qualifies x/y/carry_in for capture into the registered path
//   sum, carry_out   combinational sum bits and carry out of the MSB slice
//   overflow         combinational two's-complement overflow
//   sum_q, carry_out_q, overflow_q, valid_q   registered copies and result-valid flag
module four_bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] x,
  input  logic [0:3] y,
  input  logic       carry_in,
  input  logic       in_valid,
  output logic [0:3] sum,
  output logic       carry_out,
  output logic       overflow,
  output logic [0:3] sum_q,
  output logic       carry_out_q,
  output logic       overflow_q,
  output logic       valid_q
);

  // Carry chain: c[4] feeds the LSB slice (index 3), c[i] is the carry out
  // of slice i, so c[0] is the final carry and c[1] the carry into the MSB.
  logic [0:4] c;
  logic [0:3] s;

  // Kept in one block so the chain is evaluated in ripple order.
  always_comb begin
    c    = '0;
    s    = '0;
    c[4] = carry_in;
    for (int i = 3; i >= 0; i--) begin
      s[i] = x[i] ^ y[i] ^ c[i+1];
      c[i] = (x[i] & y[i]) | (c[i+1] & (x[i] ^ y[i]));
    end
  end

  assign sum       = s;
  assign carry_out = c[0];
  // Signed overflow: carry into the sign slice differs from carry out of it.
  assign overflow  = c[1] ^ c[0];

  // Registered copy: results hold while in_valid is low; only valid_q drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q       <= sum;
        carry_out_q <= carry_out;
        overflow_q  <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
module tb_four_bit_adder;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic [0:3] x, y;
  logic       carry_in, in_valid;
  logic [0:3] sum, sum_q;
  logic       carry_out, overflow, carry_out_q, overflow_q, valid_q;

  int total = 0;
  int bad   = 0;

  logic [5:0] held;   // model of {overflow_q, carry_out_q, sum_q}
  logic [5:0] exp_now;

  four_bit_adder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .carry_in   (carry_in),
    .in_valid   (in_valid),
    .sum        (sum),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .sum_q      (sum_q),
    .carry_out_q(carry_out_q),
    .overflow_q (overflow_q),
    .valid_q    (valid_q)
  );

  // Clock stays low while clk_en is off so combinational checks see an idle clock.
  always #5 clk = clk_en ? ~clk : 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b required=%b", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic. Returns {overflow, carry_out, sum}.
  function automatic logic [5:0] ref_add(input int a, input int b, input int ci);
    int u, sa, sb, sr;
    logic ovf;
    u   = a + b + ci;
    sa  = (a > 7) ? a - 16 : a;
    sb  = (b > 7) ? b - 16 : b;
    sr  = sa + sb + ci;
    ovf = (sr > 7) || (sr < -8);
    return {ovf, 5'(u)};
  endfunction

  task automatic drive(input int a, input int b, input int ci, input logic v);
    x        = 4'(a);
    y        = 4'(b);
    carry_in = ci[0];
    in_valid = v;
  endtask

  function automatic logic [7:0] comb_obs();
    return {2'b00, overflow, carry_out, sum};
  endfunction

  function automatic logic [7:0] reg_obs();
    return {2'b00, overflow_q, carry_out_q, sum_q};
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0);
    #1;
    check("reset_regs", reg_obs(), 8'h00);
    check("reset_valid", {7'b0, valid_q}, 8'h00);

    // Directed combinational cases ({ovf, co, sum} constants worked by hand).
    drive(5, 3, 0, 1'b0);   #1; check("dir_0101_0011", comb_obs(), 8'b0010_1000);
    drive(15, 1, 0, 1'b0);  #1; check("wrap_1111_0001", comb_obs(), 8'b0001_0000);
    drive(15, 15, 1, 1'b0); #1; check("max_1111_1111_1", comb_obs(), 8'b0001_1111);
    drive(0, 0, 0, 1'b0);   #1; check("zero", comb_obs(), 8'b0000_0000);
    drive(0, 0, 1, 1'b0);   #1; check("cin_only", comb_obs(), 8'b0000_0001);
    drive(7, 1, 0, 1'b0);   #1; check("pos_ovf", comb_obs(), 8'b0010_1000);
    drive(8, 8, 0, 1'b0);   #1; check("neg_ovf", comb_obs(), 8'b0011_0000);

    // Exhaustive combinational sweep with the clock idle.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++) begin
          drive(a, b, ci, 1'b0);
          #1;
          check("exhaustive", comb_obs(), {2'b00, ref_add(a, b, ci)});
        end

    // Registered path: reset still held across an edge with in_valid high.
    clk_en = 1'b1;
    @(negedge clk);
    drive(3, 4, 0, 1'b1);
    @(posedge clk); #1;
    check("hold_in_reset_regs", reg_obs(), 8'h00);
    check("hold_in_reset_valid", {7'b0, valid_q}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    drive(2, 7, 1, 1'b1);
    @(posedge clk); #1;
    check("first_capture", reg_obs(), 8'b0010_1010);
    check("first_valid", {7'b0, valid_q}, 8'h01);

    @(negedge clk);
    drive(9, 9, 0, 1'b0);
    @(posedge clk); #1;
    check("idle_hold", reg_obs(), 8'b0010_1010);
    check("idle_valid", {7'b0, valid_q}, 8'h00);

    // Randomised stream against the model.
    held = 6'b10_1010;
    for (int n = 0; n < 300; n++) begin
      int a, b, ci;
      logic v;
      @(negedge clk);
      a  = int'($urandom_range(0, 15));
      b  = int'($urandom_range(0, 15));
      ci = int'($urandom_range(0, 1));
      v  = 1'($urandom_range(0, 1));
      drive(a, b, ci, v);
      if (v) held = ref_add(a, b, ci);
      @(posedge clk); #1;
      check("rand_regs", reg_obs(), {2'b00, held});
      check("rand_valid", {7'b0, valid_q}, {7'b0, v});
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    drive(6, 5, 1, 1'b1);
    @(posedge clk); #1;
    check("pre_reset_regs", reg_obs(), {2'b00, ref_add(6, 5, 1)});
    check("pre_reset_valid", {7'b0, valid_q}, 8'h01);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_regs", reg_obs(), 8'h00);
    check("async_reset_valid", {7'b0, valid_q}, 8'h00);
    drive(9, 12, 1, 1'b1);
    #1;
    check("comb_during_reset", comb_obs(), {2'b00, ref_add(9, 12, 1)});
    @(posedge clk); #1;
    check("reset_held_edge", reg_obs(), 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 1'b0);
    @(posedge clk); #1;
    check("post_release_idle", {7'b0, valid_q}, 8'h00);
    check("post_release_regs", reg_obs(), 8'h00);

    @(negedge clk);
    drive(15, 1, 0, 1'b1);
    @(posedge clk); #1;
    check("post_release_capture", reg_obs(), 8'b0001_0000);
    check("post_release_valid", {7'b0, valid_q}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
